// File: rtl/stack_seq_pkg.sv
// Shared encodings for the stack-machine sequencer: opcodes, trap codes,
// FSM states, decode classes and the ALU operation range.
package stack_seq_pkg;

  localparam logic [5:0] OP_NOP       = 6'd0;
  localparam logic [5:0] OP_PUSH      = 6'd1;
  localparam logic [5:0] OP_POP       = 6'd2;
  localparam logic [5:0] OP_ALU_FIRST = 6'd3;
  localparam logic [5:0] OP_ALU_LAST  = 6'd8;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

  // ALU op codes equal opcode[3:0] for opcodes 3..8; 0 means idle.
  localparam logic [3:0] ALU_IDLE  = 4'd0;
  localparam logic [3:0] ALU_FIRST = 4'd3;
  localparam logic [3:0] ALU_LAST  = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH, S_POP, S_RD_B, S_RD_A, S_EXEC, S_WB, S_ERR
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_PUSH, CLS_POP, CLS_ALU, CLS_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/stack_op_decode.sv
// Combinational opcode classifier: class, ALU op, minimum stack depth and
// whether the instruction needs a free stack slot.
module stack_op_decode
  import stack_seq_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class,
  output logic [3:0] alu_op,
  output logic [1:0] min_depth,
  output logic       needs_space
);

  always_comb begin
    op_class    = CLS_ILLEGAL;
    alu_op      = ALU_IDLE;
    min_depth   = 2'd0;
    needs_space = 1'b0;
    if (opcode == OP_NOP) begin
      op_class = CLS_NOP;
    end else if (opcode == OP_PUSH) begin
      op_class    = CLS_PUSH;
      needs_space = 1'b1;
    end else if (opcode == OP_POP) begin
      op_class  = CLS_POP;
      min_depth = 2'd1;
    end else if (opcode >= OP_ALU_FIRST && opcode <= OP_ALU_LAST) begin
      // Two pops precede the write-back, so no free slot is needed.
      op_class  = CLS_ALU;
      alu_op    = opcode[3:0];
      min_depth = 2'd2;
    end
  end

endmodule

// File: rtl/stack_sequencer.sv
// Multi-cycle stack-machine sequencer with occupancy tracking and sticky traps.
// Define STACK_SEQ_ILLEGAL_TRAP_EN to trap opcodes 9..63 instead of treating them as NOP.
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [5:0]        opcode,
  input  logic [DATA_W-1:0] imm,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_wdata,
  input  logic [DATA_W-1:0] stk_rdata,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic [CNT_W-1:0]  depth,
  output logic              busy,
  output logic              error,
  output logic [1:0]        err_code
);

  state_t            state, state_d;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] imm_q, a_q, b_q, r_q;
  logic [1:0]        trap_code;
  logic              accept;

  op_class_t  dec_class;
  logic [3:0] dec_alu_op;
  logic [1:0] dec_min_depth;
  logic       dec_needs_space;

  stack_op_decode u_dec (
    .opcode      (opcode),
    .op_class    (dec_class),
    .alu_op      (dec_alu_op),
    .min_depth   (dec_min_depth),
    .needs_space (dec_needs_space)
  );

  assign accept = instr_valid && instr_ready;

  always_comb begin
    state_d     = state;
    trap_code   = ERR_NONE;
    instr_ready = (state == S_IDLE);
    busy        = (state != S_IDLE) && (state != S_ERR);
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_wdata   = '0;
    alu_op      = ALU_IDLE;
    alu_a       = '0;
    alu_b       = '0;
    case (state)
      S_IDLE: if (instr_valid) begin
        // Traps are judged against the depth seen at accept.
        if (dec_needs_space && depth >= CNT_W'(DEPTH)) begin
          state_d   = S_ERR;
          trap_code = ERR_OVERFLOW;
        end else if (depth < CNT_W'(dec_min_depth)) begin
          state_d   = S_ERR;
          trap_code = ERR_UNDERFLOW;
        end else begin
          case (dec_class)
            CLS_PUSH: state_d = S_PUSH;
            CLS_POP:  state_d = S_POP;
            CLS_ALU:  state_d = S_RD_B;
`ifdef STACK_SEQ_ILLEGAL_TRAP_EN
            CLS_ILLEGAL: begin
              state_d   = S_ERR;
              trap_code = ERR_ILLEGAL;
            end
`endif
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_PUSH: begin
        stk_push  = 1'b1;
        stk_wdata = imm_q;
        state_d   = S_IDLE;
      end
      S_POP: begin
        stk_pop = 1'b1;
        state_d = S_IDLE;
      end
      S_RD_B: begin
        stk_pop = 1'b1;
        state_d = S_RD_A;
      end
      S_RD_A: begin
        stk_pop = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_op  = op_q;
        alu_a   = a_q;
        alu_b   = b_q;
        state_d = S_WB;
      end
      S_WB: begin
        stk_push  = 1'b1;
        stk_wdata = r_q;
        state_d   = S_IDLE;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= S_IDLE;
      depth    <= '0;
      error    <= 1'b0;
      err_code <= ERR_NONE;
      op_q     <= ALU_IDLE;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_q  <= dec_alu_op;
        imm_q <= imm;
      end
      if (state == S_IDLE && state_d == S_ERR) begin
        error    <= 1'b1;
        err_code <= trap_code;
      end
      if (stk_push)     depth <= depth + CNT_W'(1);
      else if (stk_pop) depth <= depth - CNT_W'(1);
      if (state == S_RD_B) b_q <= stk_rdata;
      if (state == S_RD_A) a_q <= stk_rdata;
      if (state == S_EXEC) r_q <= alu_result;
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with an attached stack/ALU model and a
// push-data scoreboard; honours STACK_SEQ_ILLEGAL_TRAP_EN like the design.
module tb_stack_sequencer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clock, reset, instr_valid, instr_ready;
  logic [5:0]        opcode;
  logic [DATA_W-1:0] imm, stk_wdata, stk_rdata, alu_a, alu_b, alu_result;
  logic              stk_push, stk_pop, busy, error;
  logic [3:0]        alu_op;
  logic [CNT_W-1:0]  depth;
  logic [1:0]        err_code;

  int n_checks = 0;
  int n_fail   = 0;
  int pop_seen = 0;
  int m_pops   = 0;
  logic       m_err  = 1'b0;
  logic [1:0] m_code = 2'd0;
  logic [15:0] mstk[$];
  logic [15:0] exp_q[$];

  stack_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .imm(imm), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_result(alu_result), .depth(depth), .busy(busy),
    .error(error), .err_code(err_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd3: return a + b;
      4'd4: return a - b;
      4'd5: return a & b;
      4'd6: return a | b;
      4'd7: return a ^ b;
      4'd8: return 16'(a * b);
      default: return 16'h0;
    endcase
  endfunction

  // Attached stack and ALU
  logic [15:0] smem [16];
  logic [3:0]  sp;
  always @(posedge clock) begin
    if (!reset) sp <= 4'd0;
    else if (stk_push) begin
      smem[sp] <= stk_wdata;
      sp <= sp + 4'd1;
    end else if (stk_pop) sp <= sp - 4'd1;
  end
  assign stk_rdata  = (sp != 4'd0) ? smem[sp - 4'd1] : 16'h0;
  assign alu_result = alu_f(alu_op, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      if (stk_push) begin
        check("push_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("push_data", 32'(stk_wdata), 32'(exp_q.pop_front()));
      end
      if (stk_pop) pop_seen++;
      if (stk_push && stk_pop) check("push_pop_exclusive", 32'd1, 32'd0);
    end
  end

  task automatic predict(input logic [5:0] op, input logic [15:0] v);
    logic [15:0] a, b, r;
    if (m_err) return;
    if (op == 6'd1) begin
      if (mstk.size() >= DEPTH) begin m_err = 1'b1; m_code = 2'd1; end
      else begin mstk.push_back(v); exp_q.push_back(v); end
    end else if (op == 6'd2) begin
      if (mstk.size() == 0) begin m_err = 1'b1; m_code = 2'd2; end
      else begin void'(mstk.pop_back()); m_pops++; end
    end else if (op >= 6'd3 && op <= 6'd8) begin
      if (mstk.size() < 2) begin m_err = 1'b1; m_code = 2'd2; end
      else begin
        b = mstk.pop_back();
        a = mstk.pop_back();
        r = alu_f(op[3:0], a, b);
        mstk.push_back(r);
        exp_q.push_back(r);
        m_pops += 2;
      end
    end else if (op != 6'd0) begin
`ifdef STACK_SEQ_ILLEGAL_TRAP_EN
      m_err = 1'b1;
      m_code = 2'd3;
`endif
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    instr_valid = 1'b0;
    @(posedge clock); #1;
    mstk.delete(); exp_q.delete();
    m_err = 1'b0; m_code = 2'd0; m_pops = 0; pop_seen = 0;
    reset = 1'b1;
  endtask

  task automatic send(input logic [5:0] op, input logic [15:0] v);
    int n = 0;
    while (!instr_ready && n < 64) begin @(posedge clock); #1; n++; end
    check("ready_wait", 32'(instr_ready), 32'd1);
    opcode = op; imm = v; instr_valid = 1'b1;
    predict(op, v);
    @(posedge clock); #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 32) begin @(posedge clock); #1; n++; end
    check("idle_timeout", 32'(busy), 32'd0);
    check("depth", 32'(depth), 32'(mstk.size()));
    check("error", 32'(error), 32'(m_err));
    check("err_code", 32'(err_code), 32'(m_code));
    check("pop_count", 32'(pop_seen), 32'(m_pops));
    check("push_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [5:0]  b2b_op  [8];
    logic [15:0] b2b_imm [8];
    int n;
    reset = 1'b0; instr_valid = 1'b0; opcode = 6'd0; imm = 16'h0;
    @(posedge clock); #1;
    do_reset();

    // Reset state
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stk", 32'({stk_push, stk_pop}), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);

    // PUSH 5, PUSH 3, ADD: step through each state
    send(6'd1, 16'd5);
    check("push_state_push", 32'(stk_push), 32'd1);
    check("push_state_wdata", 32'(stk_wdata), 32'd5);
    check("push_state_ready", 32'(instr_ready), 32'd0);
    wait_idle();
    send(6'd1, 16'd3);
    wait_idle();
    send(6'd3, 16'd0);
    check("rdb_pop", 32'(stk_pop), 32'd1);
    check("rdb_alu_op", 32'(alu_op), 32'd0);
    @(posedge clock); #1;
    check("rda_pop", 32'(stk_pop), 32'd1);
    check("rda_depth", 32'(depth), 32'd1);
    @(posedge clock); #1;
    check("exec_alu_op", 32'(alu_op), 32'd3);
    check("exec_alu_a", 32'(alu_a), 32'd5);
    check("exec_alu_b", 32'(alu_b), 32'd3);
    check("exec_depth", 32'(depth), 32'd0);
    @(posedge clock); #1;
    check("wb_push", 32'(stk_push), 32'd1);
    check("wb_ready", 32'(instr_ready), 32'd0);
    @(posedge clock); #1;
    check("alu_ready_after_5", 32'(instr_ready), 32'd1);
    wait_idle();

    // Opcode 12 at depth 1
    send(6'd12, 16'hFFFF);
`ifdef STACK_SEQ_ILLEGAL_TRAP_EN
    check("illegal_ready", 32'(instr_ready), 32'd0);
`else
    check("illegal_ready", 32'(instr_ready), 32'd1);
    check("illegal_quiet", 32'({stk_push, stk_pop, busy}), 32'd0);
`endif
    wait_idle();

    // Overflow on the ninth push
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send(6'd1, 16'h00AA);
      wait_idle();
    end
    check("ovf_ready", 32'(instr_ready), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("ovf_ready_held", 32'(instr_ready), 32'd0);
    check("ovf_depth", 32'(depth), 32'd8);

    // Underflow: POP on empty, ALU op with one entry
    do_reset();
    send(6'd2, 16'h0);
    wait_idle();
    do_reset();
    send(6'd1, 16'h0007);
    wait_idle();
    send(6'd5, 16'h0);
    wait_idle();

    // Reset during RD_A abandons the instruction
    do_reset();
    send(6'd1, 16'h0011); wait_idle();
    send(6'd1, 16'h0022); wait_idle();
    send(6'd4, 16'h0);
    @(posedge clock); #1;
    check("mid_in_rda", 32'(stk_pop), 32'd1);
    reset = 1'b0;
    @(posedge clock); #1;
    check("mid_rst_depth", 32'(depth), 32'd0);
    check("mid_rst_pop", 32'(stk_pop), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    do_reset();

    // Back-to-back with instr_valid held high
    b2b_op  = '{6'd1, 6'd1, 6'd2, 6'd0, 6'd1, 6'd2, 6'd2, 6'd0};
    b2b_imm = '{16'h0011, 16'h0022, 16'h0, 16'h0, 16'h0033, 16'h0, 16'h0, 16'h0};
    instr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      opcode = b2b_op[i]; imm = b2b_imm[i];
      check("b2b_ready", 32'(instr_ready), 32'd1);
      predict(b2b_op[i], b2b_imm[i]);
      @(posedge clock); #1;
      if (i == 7) instr_valid = 1'b0;
      n = 1;
      while (!instr_ready && n < 16) begin @(posedge clock); #1; n++; end
      check("b2b_cycles", 32'(n), (b2b_op[i] == 6'd0) ? 32'd1 : 32'd2);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Multi-cycle controller that sequences the stack-machine datapath.
- Accepts one instruction at a time over a valid/ready handshake.
- Drives stack push/pop and operand capture, issues one ALU operation, and writes the result back to the stack.
- Tracks stack occupancy and traps overflow/underflow.
- Sits between instruction fetch and the stack + ALU, replacing the flat opcode decode with real sequencing.

Parameters:
- DATA_W, 16, width of stack entries, immediates and ALU operands.
- DEPTH, 8, stack capacity in entries; must match the attached stack instance.
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept an instruction.
- opcode  in  6  instruction opcode.
- imm  in  DATA_W  immediate value for PUSH.
- stk_push  out  1  push stk_wdata this cycle.
- stk_pop  out  1  pop top-of-stack this cycle.
- stk_wdata  out  DATA_W  data to push.
- stk_rdata  in  DATA_W  current top-of-stack (combinational read).
- alu_op  out  4  ALU operation code; 0 when idle.
- alu_a  out  DATA_W  ALU operand A (second-from-top).
- alu_b  out  DATA_W  ALU operand B (top).
- alu_result  in  DATA_W  ALU result (combinational).
- depth  out  CNT_W  current stack occupancy.
- busy  out  1  instruction in flight.
- error  out  1  sticky trap flag.
- err_code  out  2  0 none, 1 overflow, 2 underflow, 3 illegal opcode.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, depth=0, error=0, err_code=0.
  - All stk_*, alu_* and busy outputs are 0; instr_ready=1 after reset deasserts.
  - Reset mid-instruction abandons the instruction with no further push/pop; the attached stack is reset by the same signal.
- Opcodes:
  - 0 NOP
  - 1 PUSH imm
  - 2 POP
  - 3..8 binary ALU ops, with alu_op = opcode[3:0]
  - 9..63 illegal
- FSM states: IDLE, PUSH, POP, RD_B, RD_A, EXEC, WB, ERR. All stk_*/alu_* outputs are Moore, decoded from state.
- Handshake:
  - instr_ready=1 only in IDLE; an instruction is accepted on instr_valid & instr_ready.
  - opcode and imm are registered on accept.
  - busy=1 in every state except IDLE and ERR.
- Trap checks are made at accept, against the depth at accept:
  - PUSH with depth==DEPTH -> ERR, err_code=1.
  - POP with depth==0 -> ERR, err_code=2.
  - ALU op with depth<2 -> ERR, err_code=2.
  - A trapped instruction causes no stack activity.
- Per-opcode sequencing:
  - NOP: consumed in the accept cycle; stays IDLE.
  - PUSH: next cycle stk_push=1, stk_wdata=imm_q; depth+1; then IDLE. 2 cycles per PUSH.
  - POP: next cycle stk_pop=1; depth-1; then IDLE.
  - ALU op:
    - RD_B: b_q<=stk_rdata, stk_pop=1.
    - RD_A: a_q<=stk_rdata, stk_pop=1.
    - EXEC: alu_op=op_q, alu_a=a_q, alu_b=b_q; r_q<=alu_result.
    - WB: stk_push=1, stk_wdata=r_q.
    - Then IDLE. 5 cycles accept-to-IDLE; net depth -1.
- alu_op, alu_a and alu_b are 0 outside EXEC.
- depth changes by exactly one per push or pop cycle. It never wraps; the traps guarantee this.
- ERR is sticky: error=1, instr_ready=0, busy=0; exit only via reset.
- stk_push and stk_pop are never both 1 in the same cycle.

Optional Feature:
- Macro: STACK_SEQ_ILLEGAL_TRAP_EN.
- Defined: opcodes 9..63 go to ERR with err_code=3 at accept.
- Undefined: opcodes 9..63 are consumed as NOP, with no trap and no stack activity.

Decomposition:
- Shared package stack_seq_pkg:
  - opcode localparams (OP_NOP, OP_PUSH, OP_POP, OP_ALU_FIRST=3, OP_ALU_LAST=8)
  - err_code constants
  - FSM state encoding
  - ALU op encoding shared with the ALU
- One combinational sub-module, stack_op_decode:
  - input: opcode
  - outputs: op class (nop/push/pop/alu/illegal), alu_op, min_depth required, needs_space flag

Test Plan:
- Reset then PUSH 5, PUSH 3, opcode 3 -> depth 1→2→1; in EXEC alu_a=5, alu_b=3, alu_op=3; WB pushes alu_result; exactly 5 cycles from accept to instr_ready=1.
- PUSH 0x00AA with DEPTH=8, nine times -> first eight accepted, depth=8; ninth -> error=1, err_code=1, no stk_push; instr_ready stays 0.
- From reset, POP -> error=1, err_code=2, stk_pop never asserted; with depth=1, opcode 5 -> err_code=2.
- Assert reset==0 during RD_A of an ALU op -> next cycle state IDLE, depth=0, stk_pop=0, error=0.
- Opcode 12 with the macro undefined -> consumed in 1 cycle, no outputs toggle; with the macro defined -> error=1, err_code=3.
- instr_valid held high with back-to-back PUSH/POP/NOP -> instr_ready low exactly during in-flight cycles; no instruction dropped or duplicated (scoreboard on depth).
